// File: rtl/datapath_pipe.sv
// Two-stage (issue/execute) datapath: register file, operand select with forwarding,
// ALU with registered flags and an iterative shift-add multiplier.
module datapath_pipe #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int IMM_W    = 21,
  parameter int SHAMT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] regAddr_1,
  input  logic [ADDR_W-1:0] regAddr_2,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              regWriteEnable,
  input  logic [3:0]        alu_control,
  input  logic              ALU_src,
  input  logic [IMM_W-1:0]  immediate_const,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              sign_flag,
  output logic              overflow_flag
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_SLT = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  state_t r_state, w_nextState, w_issueState;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic                r_exWe;
  logic [ADDR_W-1:0]   r_exWrAddr;
  logic [3:0]          r_exOp;
  logic [DATA_W-1:0]   r_exA, r_exB;
  logic [CNT_W-1:0]    r_mulCnt;
  logic [2*DATA_W-1:0] r_mulProd;

  logic                w_accept, w_lastMul, w_exDone, w_exWrite;
  logic                w_fwdA, w_fwdB;
  logic [DATA_W-1:0]   w_regA, w_regB, w_opA, w_opB, w_immExt;
  logic [DATA_W-1:0]   w_exResult;
  logic                w_exCarry, w_exOverflow;
  logic [DATA_W:0]     w_addSum, w_subDiff, w_mulSum;
  logic [DATA_W:0]     w_sllExt, w_srlExt, w_sraExt;
  logic [SHAMT_W-1:0]  w_shamt;
  logic [2*DATA_W-1:0] w_mulNext;

  assign w_lastMul = (r_state == MUL) && (r_mulCnt == LAST_CNT);
  assign in_ready  = (r_state != MUL) || w_lastMul;
  assign w_accept  = in_valid && in_ready;
  assign w_exDone  = (r_state == EXEC) || w_lastMul;
  assign w_exWrite = w_exDone && r_exWe && (r_exWrAddr != '0) && (int'(r_exWrAddr) < NUM_REGS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_issueState = IDLE;
    if (w_accept) w_issueState = (alu_control == OP_MUL) ? MUL : EXEC;
    w_nextState = r_state;
    case (r_state)
      IDLE, EXEC: w_nextState = w_issueState;
      MUL:        w_nextState = w_lastMul ? w_issueState : MUL;
      default:    w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_regA = '0;
    w_regB = '0;
    if (regAddr_1 != '0 && int'(regAddr_1) < NUM_REGS) w_regA = r_regs[regAddr_1];
    if (regAddr_2 != '0 && int'(regAddr_2) < NUM_REGS) w_regB = r_regs[regAddr_2];
  end

  // A completing EX result bypasses the register file write it is about to make.
  assign w_fwdA   = w_exWrite && (r_exWrAddr == regAddr_1);
  assign w_fwdB   = w_exWrite && (r_exWrAddr == regAddr_2);
  assign w_immExt = {{(DATA_W-IMM_W){immediate_const[IMM_W-1]}}, immediate_const};
  assign w_opA    = w_fwdA ? w_exResult : w_regA;
  assign w_opB    = ALU_src ? w_immExt : (w_fwdB ? w_exResult : w_regB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_exWrite) begin
      r_regs[r_exWrAddr] <= w_exResult;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exWe     <= 1'b0;
      r_exWrAddr <= '0;
      r_exOp     <= '0;
      r_exA      <= '0;
      r_exB      <= '0;
    end else if (w_accept) begin
      r_exWe     <= regWriteEnable;
      r_exWrAddr <= wr_addr;
      r_exOp     <= alu_control;
      r_exA      <= w_opA;
      r_exB      <= w_opB;
    end
  end

  // Right-shifting product register: upper half accumulates, lower half holds the multiplier.
  assign w_mulSum  = {1'b0, r_mulProd[2*DATA_W-1:DATA_W]} + (r_mulProd[0] ? {1'b0, r_exA} : '0);
  assign w_mulNext = {w_mulSum, r_mulProd[DATA_W-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mulProd <= '0;
      r_mulCnt  <= '0;
    end else if (w_accept && alu_control == OP_MUL) begin
      r_mulProd <= {{DATA_W{1'b0}}, w_opB};
      r_mulCnt  <= '0;
    end else if (w_lastMul) begin
      r_mulCnt  <= '0;
    end else if (r_state == MUL) begin
      r_mulProd <= w_mulNext;
      r_mulCnt  <= r_mulCnt + 1'b1;
    end
  end

  assign w_addSum  = {1'b0, r_exA} + {1'b0, r_exB};
  assign w_subDiff = {1'b0, r_exA} - {1'b0, r_exB};
  assign w_shamt   = r_exB[SHAMT_W-1:0];
  assign w_sllExt  = {1'b0, r_exA} << w_shamt;
  assign w_srlExt  = {r_exA, 1'b0} >> w_shamt;
  assign w_sraExt  = $unsigned($signed({r_exA, 1'b0}) >>> w_shamt);

  always_comb begin
    w_exResult   = r_exB;
    w_exCarry    = 1'b0;
    w_exOverflow = 1'b0;
    case (r_exOp)
      OP_ADD: begin
        w_exResult   = w_addSum[DATA_W-1:0];
        w_exCarry    = w_addSum[DATA_W];
        w_exOverflow = (r_exA[DATA_W-1] == r_exB[DATA_W-1]) && (w_addSum[DATA_W-1] != r_exA[DATA_W-1]);
      end
      OP_SUB: begin
        w_exResult   = w_subDiff[DATA_W-1:0];
        w_exCarry    = w_subDiff[DATA_W];
        w_exOverflow = (r_exA[DATA_W-1] != r_exB[DATA_W-1]) && (w_subDiff[DATA_W-1] != r_exA[DATA_W-1]);
      end
      OP_AND: w_exResult = r_exA & r_exB;
      OP_OR:  w_exResult = r_exA | r_exB;
      OP_XOR: w_exResult = r_exA ^ r_exB;
      OP_NOT: w_exResult = ~r_exA;
      OP_SLL: begin
        w_exResult = w_sllExt[DATA_W-1:0];
        w_exCarry  = w_sllExt[DATA_W];
      end
      OP_SRL: begin
        w_exResult = w_srlExt[DATA_W:1];
        w_exCarry  = w_srlExt[0];
      end
      OP_SRA: begin
        w_exResult = w_sraExt[DATA_W:1];
        w_exCarry  = w_sraExt[0];
      end
      OP_SLT: w_exResult = {{(DATA_W-1){1'b0}}, ($signed(r_exA) < $signed(r_exB))};
      OP_MUL: begin
        w_exResult = w_mulNext[DATA_W-1:0];
        w_exCarry  = |w_mulNext[2*DATA_W-1:DATA_W];
      end
      default: w_exResult = r_exB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      alu_result    <= '0;
      zero_flag     <= 1'b0;
      carry_flag    <= 1'b0;
      sign_flag     <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      out_valid <= w_exDone;
      if (w_exDone) begin
        alu_result    <= w_exResult;
        zero_flag     <= (w_exResult == '0);
        carry_flag    <= w_exCarry;
        sign_flag     <= w_exResult[DATA_W-1];
        overflow_flag <= w_exOverflow;
      end
    end
  end

endmodule

// File: doc/datapath_pipe.md
Name: datapath_pipe

Overview:
- Parametrised two-stage (issue/execute) successor to the single-cycle KGP-RISC datapath.
- Contains the register file, operand select with sign-extended immediate, EX-to-issue forwarding, an ALU with registered flags, and an iterative multiplier.
- Uses a valid/ready issue handshake; back-pressure applies only while a multiply runs.
- Sits between the control unit (decoded fields) and the branch logic, which consumes the flags.

Parameters:
- DATA_W, 32, datapath, register and ALU width.
- NUM_REGS, 32, number of architectural registers; R0 reads as zero.
- ADDR_W, 5, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- IMM_W, 21, immediate field width; sign-extended to DATA_W.
- SHAMT_W, 5, shift-count width, clog2(DATA_W).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded instruction fields are valid.
- in_ready  out  1  datapath accepts an instruction on this edge.
- regAddr_1  in  ADDR_W  source register A.
- regAddr_2  in  ADDR_W  source register B.
- wr_addr  in  ADDR_W  destination register.
- regWriteEnable  in  1  write the result to wr_addr.
- alu_control  in  4  operation code.
- ALU_src  in  1  1 selects sign-extended immediate_const as B; 0 selects R[regAddr_2].
- immediate_const  in  IMM_W  immediate operand.
- out_valid  out  1  one-cycle pulse when an instruction completes.
- alu_result  out  DATA_W  result of the last completed instruction.
- zero_flag, carry_flag, sign_flag, overflow_flag  out  1 each  flags of the last completed instruction.

Behaviour:
- Reset (async, takes effect immediately, including mid-multiply):
  - all registers = 0, EX stage empty, multiply counter = 0.
  - out_valid = 0, alu_result = 0, all flags = 0, in_ready = 1.
  - An aborted multiply writes nothing.
- Accept: the instruction is captured into the EX register on an edge where in_valid && in_ready.
- Operand read is combinational at issue.
  - R0 always reads 0; writes to R0 are discarded.
  - Forwarding: if EX holds a completing instruction with regWriteEnable=1 and wr_addr equal to the source address (nonzero), the issuing instruction takes the EX result rather than the register file value.
- Single-cycle ops, accepted at edge N:
  - At edge N+1: register write, alu_result and flags updated; out_valid = 1 for the cycle after edge N+1.
  - Back-to-back issue every cycle is supported.
- Operation codes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A.
  - 6 SLL, 7 SRL, 8 SRA; shift count = B[SHAMT_W-1:0].
  - 9 SLT (signed; result 1 or 0), 10 MUL (low DATA_W bits of the product).
  - 11-15 pass B.
- Flags, updated only on completion, otherwise held:
  - zero_flag = (result == 0); sign_flag = result MSB.
  - ADD: carry = carry-out, overflow = signed overflow.
  - SUB: carry = borrow (A < B unsigned), overflow = signed overflow.
  - Shifts: carry = last bit shifted out (0 when count = 0); overflow = 0.
  - Logic, SLT and pass ops: carry = overflow = 0.
  - MUL: carry = 1 if any upper product bit is nonzero; overflow = 0.
- MUL: iterative shift-add over DATA_W cycles; states IDLE/EXEC/MUL.
  - EXEC to MUL when a MUL is captured. MUL to EXEC/IDLE when counter = DATA_W-1.
  - in_ready = 0 from the edge after acceptance until the last MUL cycle.
  - in_ready = 1 during the last MUL cycle, so the next instruction issues with the product forwarded.
  - Accepted at edge N, the MUL completes at edge N+DATA_W.
- No issue while in_valid = 0: EX empties, out_valid = 0, outputs hold.

Test Plan:
1. Pulse rst mid-stream, then issue ADD R3 = R5 + R0 -> in_ready=1 and all flags 0 right after reset; result 0, zero_flag=1.
2. ADDI R1 = R0 + 20, then ADD R2 = R1 + R1 on the next cycle -> alu_result 20, then 40 (forwarded); out_valid high two consecutive cycles.
3. SUB 5-7 -> 0xFFFFFFFE, sign=1, carry=1, zero=0. ADD 0x7FFFFFFF + 1 -> 0x80000000, overflow=1, carry=0.
4. MUL R4 = 1234 * 5678 -> 7006652; in_ready low for 31 cycles; out_valid after edge N+32. A dependent ADD R5 = R4 + 1 issued in the last MUL cycle -> 7006653.
5. SRA 0x80000000 by 4 -> 0xF8000000, carry=0. SLL 0x80000001 by 1 -> 0x00000002, carry=1. ADDI R0 = 99 then read R0 -> 0.
6. R6 = 7, then MUL R6 = 3 * 3 with rst asserted at multiply cycle 10 -> immediate reset; no write or out_valid from the aborted MUL; all registers 0 (R6 reads 0); in_ready=1.
